// File: rtl/weighted_rr_arbiter.sv
// ============================================================================
// Module      : weighted_rr_arbiter
// Description : N-way weighted round-robin arbiter with registered one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module weighted_rr_arbiter #(
  parameter  int N        = 4,
  parameter  int WEIGHT_W = 4,
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          request,
  input  logic [N*WEIGHT_W-1:0] weight,
  output logic [N-1:0]          grant,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [WEIGHT_W-1:0] r_credit, w_credit_nxt;
  logic [N-1:0]        r_grant, w_grant_nxt;
  logic                r_valid, w_valid_nxt;

  logic [IDX_W-1:0]    w_idx_inc;
  logic [IDX_W-1:0]    w_arb_ptr;
  logic [IDX_W-1:0]    w_win_idx;
  logic [IDX_W:0]      w_sum;
  logic                w_found;
  logic [WEIGHT_W-1:0] w_win_wt;
  logic [N-1:0]        w_win_oh;
  logic                w_any;
  logic                w_release;

  assign w_any     = |request;
  assign w_idx_inc = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + IDX_W'(1);
  // While granting, the search already starts after the holder so a release
  // can hand over in the same edge.
  assign w_arb_ptr = (r_state == GRANT) ? w_idx_inc : r_ptr;
  assign w_release = (r_state == GRANT) &&
                     (!request[r_idx] || (r_credit == WEIGHT_W'(1)));

  always_comb begin
    w_win_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, w_arb_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      if (!w_found && request[w_sum[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = w_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_win_wt = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win_idx == IDX_W'(i)) begin
        w_win_wt = weight[i*WEIGHT_W +: WEIGHT_W];
      end
    end
    // A zero weight still earns one beat.
    if (w_win_wt == '0) begin
      w_win_wt = WEIGHT_W'(1);
    end
  end

  assign w_win_oh = N'(1) << w_win_idx;

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_idx_nxt    = r_idx;
    w_credit_nxt = r_credit;
    w_grant_nxt  = r_grant;
    w_valid_nxt  = r_valid;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt  = GRANT;
          w_grant_nxt  = w_win_oh;
          w_idx_nxt    = w_win_idx;
          w_credit_nxt = w_win_wt;
          w_valid_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_idx_inc;
          if (w_any) begin
            w_grant_nxt  = w_win_oh;
            w_idx_nxt    = w_win_idx;
            w_credit_nxt = w_win_wt;
            w_valid_nxt  = 1'b1;
          end else begin
            w_state_nxt  = IDLE;
            w_grant_nxt  = '0;
            w_idx_nxt    = '0;
            w_credit_nxt = '0;
            w_valid_nxt  = 1'b0;
          end
        end else begin
          w_credit_nxt = r_credit - WEIGHT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_credit <= '0;
      r_grant  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_idx    <= w_idx_nxt;
      r_credit <= w_credit_nxt;
      r_grant  <= w_grant_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_idx   = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_weighted_rr_arbiter.sv
// ============================================================================
// Module      : tb_weighted_rr_arbiter
// Description : Scoreboard bench for weighted_rr_arbiter (N=4 and N=5 instances)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_weighted_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  request;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_idx;

  logic [4:0]  request5;
  logic [19:0] weight5;
  logic [4:0]  grant5;
  logic        grant_valid5;
  logic [2:0]  grant_idx5;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];
  logic [4:0] exp5_q[$];

  always #5 clk = ~clk;

  weighted_rr_arbiter #(.N(4), .WEIGHT_W(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .weight      (weight),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  weighted_rr_arbiter #(.N(5), .WEIGHT_W(4)) u_dut5 (
    .clk         (clk),
    .rst         (rst),
    .request     (request5),
    .weight      (weight5),
    .grant       (grant5),
    .grant_valid (grant_valid5),
    .grant_idx   (grant_idx5)
  );

  function automatic logic [2:0] oh_idx(input logic [4:0] oh);
    for (int i = 0; i < 5; i++) begin
      if (oh[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic apply_reset();
    rst      = 1'b0;
    request  = '0;
    request5 = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst      = 1'b0;
    request  = 4'b1111;
    weight   = 16'h1111;
    request5 = '0;
    weight5  = 20'h11111;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000);
    end
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected %b", grant_valid, 1'b0);
    end
    checks++;
    if (grant_idx !== 2'd0) begin
      errors++; $display("FAIL reset_idx: got %0d expected 0", grant_idx);
    end
    rst = 1'b1;
    exp_q.push_back(4'b0001);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (grant !== e) begin
      errors++; $display("FAIL reset_first_grant: got %b expected %b", grant, e);
    end
    checks++;
    if (grant_valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_valid: got %b expected 1", grant_valid);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] e;
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e) begin
        errors++; $display("FAIL fairness_grant: got %b expected %b", grant, e);
      end
      checks++;
      if (grant_idx !== 2'(oh_idx({1'b0, e}))) begin
        errors++; $display("FAIL fairness_idx: got %0d expected %0d", grant_idx, oh_idx({1'b0, e}));
      end
    end
  endtask

  task automatic test_weighted();
    logic [3:0] e;
    apply_reset();
    weight  = {4'd4, 4'd3, 4'd2, 4'd1};
    request = 4'b1111;
    exp_q.push_back(4'b0001);
    repeat (2) exp_q.push_back(4'b0010);
    repeat (3) exp_q.push_back(4'b0100);
    repeat (4) exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    repeat (2) exp_q.push_back(4'b0010);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e) begin
        errors++; $display("FAIL weighted_grant: got %b expected %b", grant, e);
      end
      checks++;
      if (grant_valid !== 1'b1) begin
        errors++; $display("FAIL weighted_valid: got %b expected 1", grant_valid);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] e;
    apply_reset();
    weight  = 16'h3333;
    request = 4'b1010;
    repeat (3) exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    repeat (9) exp_q.push_back(4'b0001);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e) begin
        errors++; $display("FAIL early_release_grant[%0d]: got %b expected %b", i, grant, e);
      end
      if (i == 3) request = 4'b0010;
      if (i == 4) request = 4'b0001;
    end
  endtask

  task automatic test_weight_zero();
    logic [3:0] e;
    apply_reset();
    weight  = {4'd3, 4'd0, 4'd3, 4'd3};
    request = 4'b0100;
    repeat (4) exp_q.push_back(4'b0100);
    repeat (3) exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e) begin
        errors++; $display("FAIL weight_zero_grant[%0d]: got %b expected %b", i, grant, e);
      end
      if (i == 3) request = 4'b0101;
    end
  endtask

  task automatic test_wrap_n5();
    logic [4:0] e;
    apply_reset();
    weight5  = 20'h11111;
    request5 = 5'b10001;
    exp5_q.push_back(5'b00001); exp5_q.push_back(5'b10000);
    exp5_q.push_back(5'b00001); exp5_q.push_back(5'b10000);
    while (exp5_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp5_q.pop_front();
      checks++;
      if (grant5 !== e) begin
        errors++; $display("FAIL wrap_n5_grant: got %b expected %b", grant5, e);
      end
      checks++;
      if (grant_idx5 !== oh_idx(e)) begin
        errors++; $display("FAIL wrap_n5_idx: got %0d expected %0d", grant_idx5, oh_idx(e));
      end
    end
    request5 = '0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    apply_reset();
    weight  = {4'd1, 4'd1, 4'd4, 4'd1};
    request = 4'b0010;
    repeat (2) exp_q.push_back(4'b0010);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e) begin
        errors++; $display("FAIL reset_mid_pre: got %b expected %b", grant, e);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_async_grant: got %b expected 0000", grant);
    end
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async_valid: got %b expected 0", grant_valid);
    end
    #2;
    rst = 1'b1;
    repeat (4) exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e) begin
        errors++; $display("FAIL reset_mid_reload[%0d]: got %b expected %b", i, grant, e);
      end
      if (i == 0) request = 4'b0011;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fairness();
    test_weighted();
    test_early_release();
    test_weight_zero();
    test_wrap_n5();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
Parametrised weighted round-robin arbiter for N requesters with registered one-hot grant.
Each winner keeps the grant for up to its programmed weight in consecutive cycles. The grant is released early when its request drops.
Priority then rotates to the requester after the last winner. The arbiter hands over back-to-back with no idle bubble.
Successor to the fixed 4-requester round-robin arbiter; sits in front of shared buses and memories.

Parameters:
N, 4, number of requesters (≥2)
WEIGHT_W, 4, width of each per-requester weight field
IDX_W, $clog2(N), width of grant_idx (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset)
request  input  N  per-requester request, level-sensitive
weight  input  N*WEIGHT_W  packed weights, requester i at [i*WEIGHT_W +: WEIGHT_W]
grant  output  N  registered one-hot grant (all-zero when idle)
grant_valid  output  1  OR of grant, registered
grant_idx  output  IDX_W  index of granted requester (0 when idle)

Behaviour:
- Reset (rst=0, asynchronous):
  - grant=0, grant_valid=0, grant_idx=0.
  - state=IDLE, pointer=0 (requester 0 highest priority), credit counter=0.
- State machine: IDLE, GRANT.
- Arbitration function:
  - Search request circularly starting at pointer; first set bit wins.
  - Purely combinational, evaluated every cycle.
- IDLE:
  - If request≠0, at next edge: grant=onehot(winner), load credit=weight[winner], go to GRANT.
  - Request-to-grant latency is 1 cycle.
  - If request=0, stay IDLE.
- GRANT holding requester g:
  - Each cycle in GRANT is one beat. Credit decrements by 1 per beat.
  - Release at an edge if request[g]==0 is sampled, or credit==1 (last beat).
  - Otherwise hold grant and decrement.
- On release at an edge:
  - pointer := (g+1) mod N.
  - Arbitrate in the same cycle using the new pointer and the current request.
  - The winner, possibly g itself if it is the only requester, is granted at that edge with credit reloaded.
  - If no request, grant=0 and go to IDLE.
  - No bubble cycle between consecutive grants.
- Grant stays high during the cycle in which its request drops; it is removed at the following edge.
- Weight handling:
  - Weight is sampled only when a grant is issued; changes mid-grant take effect at the next grant.
  - weight=0 is treated as 1.
  - Maximum hold is 2^WEIGHT_W−1 cycles.
- grant is always one-hot or zero. grant_valid and grant_idx are consistent with grant in the same cycle.
- Requests from non-granted requesters never preempt an active grant.
- Starvation bound: any asserted request is granted within sum of the other requesters' effective weights + 1 cycles.
- Reset asserted mid-grant: outputs clear immediately (asynchronous). After release, arbitration restarts from pointer=0.
- Pointer arithmetic wraps modulo N; N need not be a power of 2 (N−1 wraps to 0).

Test Plan:
- Reset: hold rst=0 with request=4'b1111 → grant=0000, grant_valid=0, grant_idx=0. Release rst → grant=0001 one cycle later.
- Fairness, all weights=1, request=4'b1111 held → grant sequence 0001,0010,0100,1000,0001 with one cycle each and no zero cycles.
- Weighted, weights {4,3,2,1} for req3..req0, request=4'b1111 → grant 0001×1, 0010×2, 0100×3, 1000×4 cycles, then repeats.
- Early release and sparse requests, weights=3:
  - request=1010 → 0010 for 3 cycles, then 1000.
  - Drop req3 after 1 cycle → 1000 ends at next edge, grant goes to 0010.
  - Then request=0001 only → 0001 re-granted continuously in 3-cycle windows with no gap.
- Weight 0 and sole requester: weight[2]=0, request=0100 → grant 0100 re-issued every cycle; pointer wraps correctly. With N=5, requester 4 → 0 wrap checked.
- Reset mid-operation: rst=0 during the 2nd beat of a weight-4 grant to req1 → grant=0 asynchronously. After release with request=0010, grant=0010 with credit reloaded to 4.
